// File: rtl/blk_addr_alloc_if.sv
// -----------------------------------------------------------------------------
// blk_addr_alloc_if
//   Bundle of request/grant and release signals between the input channels,
//   the read side and the shared free-block allocator.
//
//   master : channel/read-side view (drives requests and releases)
//   slave  : allocator view (drives grants, status and error flags)
//
//   i_addr_req     [NUM_PORTS]        per-port single-cycle request pulse
//   o_blk_addr_vld [NUM_PORTS]        one-hot grant pulse
//   o_blk_addr     [BLK_ADDR_WIDTH]   granted address, shared by all ports
//   i_free_vld                        release strobe from the read side
//   i_free_addr    [BLK_ADDR_WIDTH]   address being released
//   o_init_done                       free list populated, grants enabled
//   o_free_cnt     [BLK_ADDR_WIDTH+1] number of free blocks
//   o_req_err                         sticky duplicate-request flag
//   o_free_err                        sticky bad-release flag
// -----------------------------------------------------------------------------
interface blk_addr_alloc_if #(
  parameter int NUM_PORTS      = 16,
  parameter int BLK_ADDR_WIDTH = 11
);
  logic [NUM_PORTS-1:0]      i_addr_req;
  logic [NUM_PORTS-1:0]      o_blk_addr_vld;
  logic [BLK_ADDR_WIDTH-1:0] o_blk_addr;
  logic                      i_free_vld;
  logic [BLK_ADDR_WIDTH-1:0] i_free_addr;
  logic                      o_init_done;
  logic [BLK_ADDR_WIDTH:0]   o_free_cnt;
  logic                      o_req_err;
  logic                      o_free_err;

  modport master (
    output i_addr_req, i_free_vld, i_free_addr,
    input  o_blk_addr_vld, o_blk_addr, o_init_done, o_free_cnt, o_req_err, o_free_err
  );

  modport slave (
    input  i_addr_req, i_free_vld, i_free_addr,
    output o_blk_addr_vld, o_blk_addr, o_init_done, o_free_cnt, o_req_err, o_free_err
  );
endinterface

// File: rtl/blk_addr_alloc.sv
// -----------------------------------------------------------------------------
// blk_addr_alloc
//   Shared free-block allocator. Keeps a circular free list of SRAM block
//   addresses, hands one address per cycle to the requesting input channels
//   using round-robin arbitration, and takes back addresses released by the
//   read side once a block has been drained.
//
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      blk_addr_alloc_if.slave: requests, grants, releases, status
//
//   After reset the list is filled with addresses 0..NUM_BLKS-1 (one per
//   cycle); requests seen during that fill are remembered and served after.
// -----------------------------------------------------------------------------
module blk_addr_alloc #(
  parameter int NUM_PORTS      = 16,
  parameter int BLK_ADDR_WIDTH = 11,
  parameter int NUM_BLKS       = 2**BLK_ADDR_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  blk_addr_alloc_if.slave    bus
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = BLK_ADDR_WIDTH;
  localparam int CW = BLK_ADDR_WIDTH + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_reg,    state_next;
  logic [AW-1:0]         fill_reg,     fill_next;
  logic [AW-1:0]         rd_ptr_reg,   rd_ptr_next;
  logic [AW-1:0]         wr_ptr_reg,   wr_ptr_next;
  logic [CW-1:0]         count_reg,    count_next;
  logic [NUM_PORTS-1:0]  pend_reg,     pend_next;
  logic [PW-1:0]         rr_reg,       rr_next;
  logic [NUM_PORTS-1:0]  vld_reg,      vld_next;
  logic [AW-1:0]         addr_reg,     addr_next;
  logic                  done_reg,     done_next;
  logic                  req_err_reg,  req_err_next;
  logic                  free_err_reg, free_err_next;

  // Free list storage; contents need no reset because INIT rewrites every entry.
  logic [AW-1:0]         list_mem [NUM_BLKS];
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [AW-1:0]         mem_wdata;

  logic [NUM_PORTS-1:0]  req_eff;
  logic [NUM_PORTS-1:0]  grant_vec;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         idx_w;
  logic                  win_found;
  logic                  grant;
  logic                  free_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(NUM_BLKS - 1)) ? '0 : p + AW'(1);
  endfunction

  // A pulse on an already-pending port is absorbed by the OR; it only raises
  // the sticky error flag.
  assign req_eff = pend_reg | bus.i_addr_req;

  // Round-robin search: first set bit strictly after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_w = PW'((int'(rr_reg) + k) % NUM_PORTS);
      if (!win_found && req_eff[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign grant   = (state_reg == ST_RUN) && (count_reg != '0) && win_found;
  assign free_ok = bus.i_free_vld && (state_reg == ST_RUN) && (count_reg != CW'(NUM_BLKS));

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
    assign grant_vec[gi] = grant && (win_idx == PW'(gi));
  end

  always_comb begin
    state_next    = state_reg;
    fill_next     = fill_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    rr_next       = rr_reg;
    vld_next      = '0;
    addr_next     = addr_reg;
    done_next     = (state_reg == ST_RUN);
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    // Everything requested and not granted this cycle stays pending.
    pend_next     = req_eff & ~grant_vec;
    req_err_next  = req_err_reg | (|(pend_reg & bus.i_addr_req));
    free_err_next = free_err_reg | (bus.i_free_vld && !free_ok);

    unique case (state_reg)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = fill_reg;
        mem_wdata = fill_reg;
        fill_next = fill_reg + AW'(1);
        if (fill_reg == AW'(NUM_BLKS - 1)) begin
          fill_next  = '0;
          count_next = CW'(NUM_BLKS);
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (free_ok) begin
          mem_we      = 1'b1;
          mem_waddr   = wr_ptr_reg;
          mem_wdata   = bus.i_free_addr;
          wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (grant) begin
          // rd_ptr never equals wr_ptr on a grant with an accepted free (that
          // would need count 0 or a full list), so no write/read collision.
          vld_next    = grant_vec;
          addr_next   = list_mem[rd_ptr_reg];
          rd_ptr_next = ptr_inc(rd_ptr_reg);
          rr_next     = win_idx;
        end
        unique case ({grant, free_ok})
          2'b10:   count_next = count_reg - CW'(1);
          2'b01:   count_next = count_reg + CW'(1);
          default: count_next = count_reg;
        endcase
      end

      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_INIT;
      fill_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      pend_reg     <= '0;
      rr_reg       <= PW'(NUM_PORTS - 1);
      vld_reg      <= '0;
      addr_reg     <= '0;
      done_reg     <= 1'b0;
      req_err_reg  <= 1'b0;
      free_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_reg     <= fill_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      pend_reg     <= pend_next;
      rr_reg       <= rr_next;
      vld_reg      <= vld_next;
      addr_reg     <= addr_next;
      done_reg     <= done_next;
      req_err_reg  <= req_err_next;
      free_err_reg <= free_err_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      list_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.o_blk_addr_vld = vld_reg;
  assign bus.o_blk_addr     = addr_reg;
  assign bus.o_init_done    = done_reg;
  assign bus.o_free_cnt     = count_reg;
  assign bus.o_req_err      = req_err_reg;
  assign bus.o_free_err     = free_err_reg;

endmodule

// File: tb/tb_blk_addr_alloc.sv
// -----------------------------------------------------------------------------
// tb_blk_addr_alloc
//   Two allocator instances share one clock and reset: a full-size one (L) and
//   an 8-block one (S) used for empty-list and grant/free overlap scenarios.
//   Expected grants (cycle, one-hot valid, address) are queued when stimulus
//   is driven; the address comes from a FIFO model of the free list.
// -----------------------------------------------------------------------------
`ifndef BLK_ADDR_WIDTH
`define BLK_ADDR_WIDTH 11
`endif

module tb_blk_addr_alloc;

  localparam int NP = 16;
  localparam int LW = `BLK_ADDR_WIDTH;
  localparam int LN = 1 << LW;
  localparam int SW = 3;
  localparam int SN = 1 << SW;

  typedef struct {
    int cyc;
    int vld;
    int addr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q_l[$];
  exp_t q_s[$];
  int   fl_l[$];
  int   fl_s[$];

  blk_addr_alloc_if #(.NUM_PORTS(NP), .BLK_ADDR_WIDTH(LW)) bus_l ();
  blk_addr_alloc_if #(.NUM_PORTS(NP), .BLK_ADDR_WIDTH(SW)) bus_s ();

  blk_addr_alloc #(.NUM_PORTS(NP), .BLK_ADDR_WIDTH(LW)) dut_l (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_l.slave)
  );

  blk_addr_alloc #(.NUM_PORTS(NP), .BLK_ADDR_WIDTH(SW)) dut_s (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic exp_l(input int dly, input int port);
    exp_t e;
    e.cyc  = cyc + dly;
    e.vld  = 1 << port;
    e.addr = fl_l.pop_front();
    q_l.push_back(e);
  endtask

  task automatic exp_s(input int dly, input int port);
    exp_t e;
    e.cyc  = cyc + dly;
    e.vld  = 1 << port;
    e.addr = fl_s.pop_front();
    q_s.push_back(e);
  endtask

  task automatic model_reset();
    fl_l.delete();
    fl_s.delete();
    for (int i = 0; i < LN; i++) fl_l.push_back(i);
    for (int i = 0; i < SN; i++) fl_s.push_back(i);
  endtask

  // Grant monitors: a queued grant due this cycle must appear exactly now;
  // otherwise the valid bus must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (q_l.size() != 0 && q_l[0].cyc == cyc) begin
      e = q_l.pop_front();
      check("l_grant_vld", 32'(bus_l.o_blk_addr_vld), 32'(e.vld));
      check("l_grant_addr", 32'(bus_l.o_blk_addr), 32'(e.addr));
      $display("L grant cyc=%0d vld=0x%04h addr=0x%0h", cyc, bus_l.o_blk_addr_vld, bus_l.o_blk_addr);
    end else begin
      check("l_idle_vld", 32'(bus_l.o_blk_addr_vld), 32'(0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_s.size() != 0 && q_s[0].cyc == cyc) begin
      e = q_s.pop_front();
      check("s_grant_vld", 32'(bus_s.o_blk_addr_vld), 32'(e.vld));
      check("s_grant_addr", 32'(bus_s.o_blk_addr), 32'(e.addr));
      $display("S grant cyc=%0d vld=0x%04h addr=0x%0h", cyc, bus_s.o_blk_addr_vld, bus_s.o_blk_addr);
    end else begin
      check("s_idle_vld", 32'(bus_s.o_blk_addr_vld), 32'(0));
    end
  end

  initial begin
    int l_rise;
    int s_rise;

    rst_n = 1'b0;
    bus_l.i_addr_req = '0; bus_l.i_free_vld = 1'b0; bus_l.i_free_addr = '0;
    bus_s.i_addr_req = '0; bus_s.i_free_vld = 1'b0; bus_s.i_free_addr = '0;
    model_reset();
    repeat (3) tick();

    // Reset state
    check("l_rst_vld", 32'(bus_l.o_blk_addr_vld), 32'(0));
    check("l_rst_addr", 32'(bus_l.o_blk_addr), 32'(0));
    check("l_rst_done", 32'(bus_l.o_init_done), 32'(0));
    check("l_rst_cnt", 32'(bus_l.o_free_cnt), 32'(0));
    check("l_rst_errs", 32'({bus_l.o_req_err, bus_l.o_free_err}), 32'(0));

    // INIT length: init_done observed NUM_BLKS+1 cycles after release
    rst_n = 1'b1;
    l_rise = 0;
    s_rise = 0;
    for (int k = 1; k <= LN + 20; k++) begin
      tick();
      if (s_rise == 0 && bus_s.o_init_done) s_rise = k;
      if (l_rise == 0 && bus_l.o_init_done) l_rise = k;
      if (l_rise != 0 && s_rise != 0) break;
    end
    $display("init rise L=%0d S=%0d", l_rise, s_rise);
    check("l_init_rise", 32'(l_rise), 32'(LN + 1));
    check("s_init_rise", 32'(s_rise), 32'(SN + 1));
    check("l_init_cnt", 32'(bus_l.o_free_cnt), 32'(LN));
    check("s_init_cnt", 32'(bus_s.o_free_cnt), 32'(SN));

    // Free while full: dropped, sticky error, count unchanged
    bus_l.i_free_vld = 1'b1; bus_l.i_free_addr = LW'(12'h123);
    tick();
    bus_l.i_free_vld = 1'b0;
    check("l_free_full_err", 32'(bus_l.o_free_err), 32'(1));
    check("l_free_full_cnt", 32'(bus_l.o_free_cnt), 32'(LN));
    check("l_req_err_clean", 32'(bus_l.o_req_err), 32'(0));

    // Single request on port 5 -> address 0 next cycle
    bus_l.i_addr_req = NP'(1 << 5);
    exp_l(1, 5);
    tick();
    bus_l.i_addr_req = '0;
    check("l_cnt_after_p5", 32'(bus_l.o_free_cnt), 32'(LN - 1));

    // Ports 2 and 9 together with rr at 5: 9 wins, 2 follows one cycle later
    bus_l.i_addr_req = NP'((1 << 2) | (1 << 9));
    exp_l(1, 9);
    exp_l(2, 2);
    tick();
    bus_l.i_addr_req = '0;
    tick();
    check("l_cnt_after_2_9", 32'(bus_l.o_free_cnt), 32'(LN - 3));

    // Ports 1 and 4 with rr at 2: 4 wins, 1 pending; duplicate pulse on 1
    bus_l.i_addr_req = NP'((1 << 1) | (1 << 4));
    exp_l(1, 4);
    exp_l(2, 1);
    tick();
    bus_l.i_addr_req = NP'(1 << 1);
    tick();
    bus_l.i_addr_req = '0;
    check("l_dup_req_err", 32'(bus_l.o_req_err), 32'(1));
    check("l_cnt_after_dup", 32'(bus_l.o_free_cnt), 32'(LN - 5));
    tick();

    // Small list: four grants to port 0
    for (int i = 0; i < 4; i++) begin
      bus_s.i_addr_req = NP'(1);
      exp_s(1, 0);
      tick();
    end
    bus_s.i_addr_req = '0;
    check("s_cnt_4", 32'(bus_s.o_free_cnt), 32'(4));

    // Grant and free in the same cycle at count 4
    bus_s.i_addr_req = NP'(1 << 1);
    bus_s.i_free_vld = 1'b1; bus_s.i_free_addr = SW'(6);
    exp_s(1, 1);
    fl_s.push_back(6);
    tick();
    bus_s.i_addr_req = '0;
    bus_s.i_free_vld = 1'b0;
    check("s_cnt_overlap", 32'(bus_s.o_free_cnt), 32'(4));

    // Drain: older entries first, freed 6 last
    for (int i = 0; i < 4; i++) begin
      bus_s.i_addr_req = NP'(1 << 2);
      exp_s(1, 2);
      tick();
    end
    bus_s.i_addr_req = '0;
    check("s_cnt_empty", 32'(bus_s.o_free_cnt), 32'(0));

    // Empty list: request held pending, duplicate flagged, no grant
    bus_s.i_addr_req = NP'(1 << 2);
    tick();
    bus_s.i_addr_req = NP'(1 << 2);
    tick();
    bus_s.i_addr_req = '0;
    check("s_empty_vld", 32'(bus_s.o_blk_addr_vld), 32'(0));
    check("s_empty_req_err", 32'(bus_s.o_req_err), 32'(1));
    tick();
    check("s_empty_cnt", 32'(bus_s.o_free_cnt), 32'(0));

    // Free 5: pending port 2 gets it two cycles after the strobe
    bus_s.i_free_vld = 1'b1; bus_s.i_free_addr = SW'(5);
    fl_s.push_back(5);
    exp_s(2, 2);
    tick();
    bus_s.i_free_vld = 1'b0;
    tick();
    check("s_cnt_after_free", 32'(bus_s.o_free_cnt), 32'(0));
    check("s_free_err_clean", 32'(bus_s.o_free_err), 32'(0));
    tick();

    // Mid-stream reset with ports 11..13 left pending (rr at 1 -> 10 wins)
    bus_l.i_addr_req = NP'(16'h3C00);
    exp_l(1, 10);
    tick();
    bus_l.i_addr_req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("l_mid_rst_vld", 32'(bus_l.o_blk_addr_vld), 32'(0));
    check("l_mid_rst_addr", 32'(bus_l.o_blk_addr), 32'(0));
    check("l_mid_rst_done", 32'(bus_l.o_init_done), 32'(0));
    check("l_mid_rst_cnt", 32'(bus_l.o_free_cnt), 32'(0));
    check("l_mid_rst_errs", 32'({bus_l.o_req_err, bus_l.o_free_err}), 32'(0));
    model_reset();
    tick();
    rst_n = 1'b1;

    // Free during INIT is dropped and flagged
    repeat (5) tick();
    bus_l.i_free_vld = 1'b1; bus_l.i_free_addr = LW'(12'h7FF);
    tick();
    bus_l.i_free_vld = 1'b0;
    check("l_init_free_err", 32'(bus_l.o_free_err), 32'(1));
    for (int k = 0; k < LN + 20; k++) begin
      if (bus_l.o_init_done) break;
      tick();
    end
    check("l_reinit_done", 32'(bus_l.o_init_done), 32'(1));
    check("l_reinit_cnt", 32'(bus_l.o_free_cnt), 32'(LN));

    // Ports 3 and 7 with rr back at 15: 3 gets 0, 7 gets 1 next cycle;
    // stale pending bits 11..13 must not produce grants
    bus_l.i_addr_req = NP'((1 << 3) | (1 << 7));
    exp_l(1, 3);
    exp_l(2, 7);
    tick();
    bus_l.i_addr_req = '0;
    repeat (4) tick();
    check("l_cnt_after_3_7", 32'(bus_l.o_free_cnt), 32'(LN - 2));

    check("l_queue_drained", 32'(q_l.size()), 32'(0));
    check("s_queue_drained", 32'(q_s.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
